// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM encoding and slice width for the nibble-serial CLA adder
package cla_seq_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} st_e;
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: purely combinational 4-bit carry-lookahead slice
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;
  // every carry is expanded from g/p/ci directly so no carry ripples through the slice
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[SLICE_W-1:0];
    co   = c[SLICE_W];
  end
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: nibble-serial wide adder reusing one 4-bit CLA slice; optional subtract via CLA_SEQ_SUB_EN
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / SLICE_W;
  localparam int IW  = $clog2(NIB);

  st_e              st_q, st_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SLICE_W-1:0] sl_s;
  logic             sl_co;
  logic             last;

  cla4_slice u_slice (
    .a  (a_q[{idx_q, 2'b00} +: SLICE_W]),
    .b  (b_q[{idx_q, 2'b00} +: SLICE_W]),
    .ci (c_q),
    .s  (sl_s),
    .co (sl_co)
  );

  assign last      = idx_q == IW'(NIB - 1);
  assign in_ready  = st_q == IDLE;
  assign out_valid = st_q == DONE;
  assign sum       = sum_q;
  assign cout      = cout_q;

  // next-state: capture operands in IDLE, one nibble per RUN cycle, hold result in DONE
  always_comb begin
    st_d   = st_q;
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    c_d    = c_q;
    cout_d = cout_q;
    idx_d  = idx_q;
    case (st_q)
      IDLE: if (in_valid) begin
        a_d   = a;
        b_d   = b;
        c_d   = cin;
        idx_d = '0;
        st_d  = RUN;
`ifdef CLA_SEQ_SUB_EN
        if (sub) begin
          b_d = ~b;
          c_d = 1'b1;
        end
`endif
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: SLICE_W] = sl_s;
        c_d   = sl_co;
        idx_d = last ? '0 : idx_q + 1'b1;
        if (last) begin
          cout_d = sl_co;
          st_d   = DONE;
        end
      end
      DONE: if (out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // state registers; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      st_q   <= st_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sum_q  <= sum_d;
      c_q    <= c_d;
      cout_q <= cout_d;
      idx_q  <= idx_d;
    end
  end
endmodule
